// File: rtl/load_store_unit.sv
// Load/store unit between a CPU request/response port and a single-cycle word memory.
// Sub-word stores use read-modify-write; all accesses are little-endian.
module load_store_unit #(
  parameter int MEM_WORDS = 32,
  parameter int DADDR_W   = 32
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic               ReqValid,
  output logic               ReqReady,
  input  logic               ReqWrite,
  input  logic [1:0]         ReqSize,
  input  logic               ReqSigned,
  input  logic [31:0]        ReqAddr,
  input  logic [31:0]        ReqWData,
  output logic               RespValid,
  input  logic               RespReady,
  output logic [31:0]        RespData,
  output logic               RespErr,
  output logic [DADDR_W-1:0] DAddr,
  output logic [31:0]        DataIn,
  output logic               DataMemRW,
  input  logic [31:0]        DataOut
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] WR   = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  logic [1:0]  state;
  logic        wr_q, sgn_q, err_q;
  logic [1:0]  size_q, lane_q;
  logic [29:0] widx_q;
  logic [15:0] wdata_q;
  logic [31:0] wword_q, rdata_q;

  logic        req_err;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_val, merged;

  always_comb begin
    req_err = (ReqSize == 2'b11) ||
              (ReqSize == 2'b01 && ReqAddr[0]) ||
              (ReqSize == 2'b10 && ReqAddr[1:0] != 2'b00) ||
              ({2'b00, ReqAddr[31:2]} >= 32'(MEM_WORDS));
  end

  // Lane extraction for loads and lane merge for sub-word stores, both from the live read word.
  always_comb begin
    ld_b   = DataOut[{lane_q, 3'b000} +: 8];
    ld_h   = lane_q[1] ? DataOut[31:16] : DataOut[15:0];
    ld_val = DataOut;
    case (size_q)
      2'b00:   ld_val = {{24{sgn_q & ld_b[7]}}, ld_b};
      2'b01:   ld_val = {{16{sgn_q & ld_h[15]}}, ld_h};
      default: ld_val = DataOut;
    endcase
    merged = DataOut;
    if (size_q == 2'b00) merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
    else                 merged[{lane_q[1], 4'b0000} +: 16] = wdata_q;
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state   <= IDLE;
      wr_q    <= 1'b0;
      sgn_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'b00;
      lane_q  <= 2'b00;
      widx_q  <= '0;
      wdata_q <= '0;
      wword_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: if (ReqValid) begin
          wr_q    <= ReqWrite;
          sgn_q   <= ReqSigned;
          size_q  <= ReqSize;
          lane_q  <= ReqAddr[1:0];
          widx_q  <= ReqAddr[31:2];
          wdata_q <= ReqWData[15:0];
          wword_q <= ReqWData;
          err_q   <= req_err;
          rdata_q <= '0;
          if (req_err)                              state <= RESP;
          else if (ReqWrite && ReqSize == 2'b10)    state <= WR;
          else                                      state <= RD;
        end
        RD: begin
          if (wr_q) begin
            wword_q <= merged;
            state   <= WR;
          end else begin
            rdata_q <= ld_val;
            state   <= RESP;
          end
        end
        WR: state <= RESP;
        RESP: if (RespReady) begin
          rdata_q <= '0;
          err_q   <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    ReqReady  = (state == IDLE);
    RespValid = (state == RESP);
    RespData  = (state == RESP) ? rdata_q : 32'h0;
    RespErr   = (state == RESP) ? err_q : 1'b0;
    DAddr     = (state == RD || state == WR) ? DADDR_W'(widx_q) : '0;
    DataIn    = (state == WR) ? wword_q : 32'h0;
    DataMemRW = (state == WR);
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-level reference memory feeds a scoreboard of expected responses.
module tb_load_store_unit;
  localparam int MEM_WORDS = 32;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        ReqValid = 1'b0, ReqWrite = 1'b0, ReqSigned = 1'b0, RespReady = 1'b1;
  logic [1:0]  ReqSize = 2'b00;
  logic [31:0] ReqAddr = '0, ReqWData = '0;
  logic        ReqReady, RespValid, RespErr, DataMemRW;
  logic [31:0] RespData, DAddr, DataIn, DataOut;

  logic [31:0] mem [MEM_WORDS] = '{default: 32'h0};
  logic [7:0]  ref_mem [4*MEM_WORDS] = '{default: 8'h0};

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
    int          nwr;
    logic [31:0] wword;
    logic [31:0] waddr;
  } exp_t;
  exp_t exp_q[$];

  typedef struct packed {
    logic        w;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] a;
    logic [31:0] wd;
  } stim_t;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  load_store_unit #(.MEM_WORDS(MEM_WORDS), .DADDR_W(32)) dut (
    .CLK(CLK), .Reset(Reset), .ReqValid(ReqValid), .ReqReady(ReqReady),
    .ReqWrite(ReqWrite), .ReqSize(ReqSize), .ReqSigned(ReqSigned), .ReqAddr(ReqAddr),
    .ReqWData(ReqWData), .RespValid(RespValid), .RespReady(RespReady), .RespData(RespData),
    .RespErr(RespErr), .DAddr(DAddr), .DataIn(DataIn), .DataMemRW(DataMemRW), .DataOut(DataOut)
  );

  // Single-cycle data memory model
  assign DataOut = (DAddr < MEM_WORDS) ? mem[DAddr[4:0]] : 32'h0;
  always @(posedge CLK) if (DataMemRW && DAddr < MEM_WORDS) mem[DAddr[4:0]] <= DataIn;

  function automatic void expect_req(input logic w, input logic [1:0] sz, input logic sg,
                                     input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    int nb, base;
    logic bad;
    logic [31:0] v;
    e.data = 0; e.err = 0; e.lat = 0; e.nwr = 0; e.wword = 0; e.waddr = 0;
    nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    bad  = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) ||
           ((a >> 2) >= MEM_WORDS);
    base = int'(a & 32'hFFFF_FFFC);
    if (bad) begin
      e.err = 1; e.lat = 1;
    end else if (w) begin
      for (int i = 0; i < nb; i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
      e.wword = {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
      e.waddr = a >> 2;
      e.nwr   = 1;
      e.lat   = (sz == 2'd2) ? 2 : 3;
    end else begin
      v = 0;
      for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_mem[int'(a) + i];
      if (sg && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
      e.data = v;
      e.lat  = 2;
    end
    exp_q.push_back(e);
  endfunction

  // Drives one request with RespReady high and measures what comes back; call at IDLE, off-edge.
  task automatic issue(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rdata, output logic rerr,
                       output int lat, output int nwr, output logic [31:0] wword, output logic [31:0] waddr);
    int t;
    expect_req(w, sz, sg, a, wd);
    ReqValid = 1; ReqWrite = w; ReqSize = sz; ReqSigned = sg; ReqAddr = a; ReqWData = wd;
    RespReady = 1;
    t = 0;
    while (ReqReady !== 1'b1 && t < 50) begin @(negedge CLK); t++; end
    @(posedge CLK); #1;
    ReqValid = 0;
    lat = 0; nwr = 0; wword = 0; waddr = 0;
    do begin
      @(negedge CLK);
      lat++;
      if (DataMemRW === 1'b1) begin nwr++; wword = DataIn; waddr = DAddr; end
    end while (RespValid !== 1'b1 && lat < 20);
    rdata = RespData; rerr = RespErr;
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    Reset = 1;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if ({ReqReady, RespValid, RespErr, DataMemRW} !== 4'b1000 || RespData !== 0 || DAddr !== 0 || DataIn !== 0) begin
      errors++;
      $display("FAIL reset rdy=%b rv=%b err=%b rw=%b data=%h daddr=%h din=%h want rdy=1 others 0",
               ReqReady, RespValid, RespErr, DataMemRW, RespData, DAddr, DataIn);
    end
    Reset = 0;
  endtask

  task automatic test_word();
    stim_t s[2] = '{'{1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF},
                    '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0}};
    logic [31:0] rd, ww, wa;
    logic er;
    int lat, nwr;
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      issue(s[i].w, s[i].sz, s[i].sg, s[i].a, s[i].wd, rd, er, lat, nwr, ww, wa);
      e = exp_q.pop_front();
      checks++;
      if (rd !== e.data || er !== e.err) begin
        errors++; $display("FAIL word_resp[%0d] data=%h err=%b want data=%h err=%b", i, rd, er, e.data, e.err);
      end
      checks++;
      if (lat != e.lat || nwr != e.nwr) begin
        errors++; $display("FAIL word_timing[%0d] lat=%0d writes=%0d want lat=%0d writes=%0d", i, lat, nwr, e.lat, e.nwr);
      end
      if (e.nwr == 1) begin
        checks++;
        if (ww !== 32'hDEADBEEF || wa !== 32'd4) begin
          errors++; $display("FAIL word_write din=%h daddr=%h want din=deadbeef daddr=4", ww, wa);
        end
      end
    end
    checks++;
    if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL word_load_lit data=%h want deadbeef", rd); end
  endtask

  task automatic test_subword();
    stim_t s[7] = '{'{1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344},
                    '{1'b1, 2'd0, 1'b0, 32'h12, 32'h000000AA},
                    '{1'b0, 2'd0, 1'b1, 32'h12, 32'h0},
                    '{1'b0, 2'd1, 1'b0, 32'h12, 32'h0},
                    '{1'b1, 2'd1, 1'b0, 32'h10, 32'hFFFF8001},
                    '{1'b0, 2'd1, 1'b1, 32'h10, 32'h0},
                    '{1'b0, 2'd0, 1'b0, 32'h13, 32'h0}};
    logic [31:0] lit[7] = '{32'h11223344, 32'h11AA3344, 32'hFFFFFFAA, 32'h000011AA,
                            32'h11AA8001, 32'hFFFF8001, 32'h00000011};
    logic [31:0] rd, ww, wa;
    logic er;
    int lat, nwr;
    exp_t e;
    for (int i = 0; i < 7; i++) begin
      issue(s[i].w, s[i].sz, s[i].sg, s[i].a, s[i].wd, rd, er, lat, nwr, ww, wa);
      e = exp_q.pop_front();
      checks++;
      if (rd !== e.data || er !== e.err) begin
        errors++; $display("FAIL sub_resp[%0d] data=%h err=%b want data=%h err=%b", i, rd, er, e.data, e.err);
      end
      checks++;
      if (lat != e.lat || nwr != e.nwr) begin
        errors++; $display("FAIL sub_timing[%0d] lat=%0d writes=%0d want lat=%0d writes=%0d", i, lat, nwr, e.lat, e.nwr);
      end
      checks++;
      if ((s[i].w ? ww : rd) !== lit[i]) begin
        errors++; $display("FAIL sub_value[%0d] got=%h want=%h", i, s[i].w ? ww : rd, lit[i]);
      end
    end
  endtask

  task automatic test_errors();
    stim_t s[5] = '{'{1'b0, 2'd2, 1'b0, 32'h13, 32'h0},
                    '{1'b0, 2'd1, 1'b0, 32'h11, 32'h0},
                    '{1'b0, 2'd3, 1'b0, 32'h10, 32'h0},
                    '{1'b1, 2'd2, 1'b0, 32'h80, 32'hCAFEF00D},
                    '{1'b1, 2'd0, 1'b0, 32'h12, 32'h55}};
    logic [31:0] rd, ww, wa;
    logic er;
    int lat, nwr;
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      issue(s[i].w, s[i].sz, s[i].sg, s[i].a, s[i].wd, rd, er, lat, nwr, ww, wa);
      e = exp_q.pop_front();
      checks++;
      if (rd !== 32'h0 || er !== 1'b1 || rd !== e.data || er !== e.err) begin
        errors++; $display("FAIL err_resp[%0d] data=%h err=%b want data=0 err=1", i, rd, er);
      end
      checks++;
      if (lat != 1 || nwr != 0) begin
        errors++; $display("FAIL err_timing[%0d] lat=%0d writes=%0d want lat=1 writes=0", i, lat, nwr);
      end
    end
    // memory word 4 must be untouched by the erroring requests
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, lat, nwr, ww, wa);
    e = exp_q.pop_front();
    checks++;
    if (rd !== e.data || rd !== 32'h11AA8001) begin
      errors++; $display("FAIL err_nowrite data=%h want %h", rd, e.data);
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    logic [31:0] held;
    int t, wr_seen;
    expect_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    RespReady = 0;
    ReqValid = 1; ReqWrite = 0; ReqSize = 2'd2; ReqSigned = 0; ReqAddr = 32'h10; ReqWData = 0;
    @(posedge CLK); #1;
    // A store is offered while busy and must be ignored.
    ReqWrite = 1; ReqAddr = 32'h14; ReqWData = 32'h12345678;
    t = 0; wr_seen = 0;
    while (RespValid !== 1'b1 && t < 20) begin @(negedge CLK); t++; if (DataMemRW === 1'b1) wr_seen++; end
    e = exp_q.pop_front();
    held = RespData;
    checks++;
    if (RespValid !== 1'b1 || held !== e.data) begin
      errors++; $display("FAIL bp_first valid=%b data=%h want valid=1 data=%h", RespValid, held, e.data);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      if (DataMemRW === 1'b1) wr_seen++;
      checks++;
      if (RespValid !== 1'b1 || RespData !== held || ReqReady !== 1'b0) begin
        errors++; $display("FAIL bp_hold[%0d] valid=%b data=%h rdy=%b want valid=1 data=%h rdy=0",
                           i, RespValid, RespData, ReqReady, held);
      end
    end
    RespReady = 1; ReqValid = 0;
    @(posedge CLK); #1;
    checks++;
    if (ReqReady !== 1'b1 || RespValid !== 1'b0) begin
      errors++; $display("FAIL bp_release rdy=%b valid=%b want rdy=1 valid=0", ReqReady, RespValid);
    end
    repeat (3) begin @(negedge CLK); if (DataMemRW === 1'b1) wr_seen++; end
    checks++;
    if (wr_seen != 0) begin errors++; $display("FAIL bp_ignored writes=%0d want 0", wr_seen); end
    @(posedge CLK); #1;
  endtask

  task automatic test_reset_abort();
    int t, seen;
    ReqValid = 1; ReqWrite = 1; ReqSize = 2'd0; ReqSigned = 0; ReqAddr = 32'h21; ReqWData = 32'h77;
    @(posedge CLK); #1;
    ReqValid = 0;
    t = 0;
    while (DataMemRW !== 1'b1 && t < 10) begin @(negedge CLK); t++; end
    checks++;
    if (DataMemRW !== 1'b1) begin errors++; $display("FAIL abort_reach_wr rw=%b want 1", DataMemRW); end
    Reset = 1;
    @(posedge CLK); #1;
    Reset = 0;
    checks++;
    if (DataMemRW !== 1'b0 || RespValid !== 1'b0 || ReqReady !== 1'b1) begin
      errors++; $display("FAIL abort_state rw=%b valid=%b rdy=%b want rw=0 valid=0 rdy=1", DataMemRW, RespValid, ReqReady);
    end
    seen = 0;
    repeat (8) begin @(negedge CLK); if (RespValid === 1'b1 || DataMemRW === 1'b1) seen++; end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL abort_no_resp cycles=%0d want 0", seen); end
    // the write may or may not have landed; resync the reference to the memory model
    for (int i = 0; i < 4; i++) ref_mem[32 + i] = mem[8][8*i +: 8];
    @(posedge CLK); #1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, ww, wa, a, m;
    logic er;
    logic [1:0] sz;
    int lat, nwr;
    exp_t e;
    for (int i = 0; i < 40; i++) begin
      sz = 2'($urandom_range(0, 3));
      a  = 32'($urandom_range(0, 4*MEM_WORDS + 15));
      m  = (sz == 2'd2) ? 32'hFFFF_FFFC : (sz == 2'd1) ? 32'hFFFF_FFFE : 32'hFFFF_FFFF;
      if ($urandom_range(0, 3) != 0) a = a & m;
      issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, rd, er, lat, nwr, ww, wa);
      e = exp_q.pop_front();
      checks++;
      if (rd !== e.data || er !== e.err) begin
        errors++; $display("FAIL b2b_resp[%0d] data=%h err=%b want data=%h err=%b", i, rd, er, e.data, e.err);
      end
      checks++;
      if (lat != e.lat || nwr != e.nwr) begin
        errors++; $display("FAIL b2b_timing[%0d] lat=%0d writes=%0d want lat=%0d writes=%0d", i, lat, nwr, e.lat, e.nwr);
      end
      if (e.nwr == 1) begin
        checks++;
        if (ww !== e.wword || wa !== e.waddr) begin
          errors++; $display("FAIL b2b_write[%0d] din=%h daddr=%h want din=%h daddr=%h", i, ww, wa, e.wword, e.waddr);
        end
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    @(posedge CLK); #1;
    test_word();
    test_subword();
    test_errors();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    repeat (2) @(posedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
